// File: rtl/sawtooth_sched.sv
// sawtooth_sched: round-robin scheduler iterating one shared sawtooth-map engine for NREQ requesters.
// Define SAWTOOTH_SCHED_WATCHDOG_EN to abort an engine wait after TIMEOUT cycles with resp_err set.
module sawtooth_sched #(
    parameter int NREQ      = 4,
    parameter int PRECISION = 32,
    parameter int TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*PRECISION-1:0] req_x,
    input  logic [NREQ*PRECISION-1:0] req_eps,
    input  logic [NREQ*8-1:0]         req_iter,
    output logic [NREQ-1:0]           req_ready,
    output logic                      resp_valid,
    output logic [2:0]                resp_id,
    output logic [PRECISION-1:0]      resp_data,
    output logic                      resp_err,
    input  logic                      resp_ready,
    output logic                      eng_start,
    output logic [PRECISION-1:0]      eng_x,
    output logic [PRECISION-1:0]      eng_eps,
    input  logic                      eng_done,
    input  logic [PRECISION-1:0]      eng_result
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state_q, state_d;
    logic [2:0] last_q, last_d, id_q, id_d, gnt_id;
    logic gnt_found;
    logic [PRECISION-1:0] cur_x_q, cur_x_d, cur_eps_q, cur_eps_d;
    logic [7:0] iter_q, iter_d, count_q, count_d, gnt_iter;
`ifdef SAWTOOTH_SCHED_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic err_q, err_d;
`endif
    // Rotating priority: the first pending requester after the last one served wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_found && req_valid[(int'(last_q) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_id = 3'((int'(last_q) + k) % NREQ);
            end
        end
    end
    assign gnt_iter = req_iter[gnt_id*8 +: 8];
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        id_d = id_q;
        cur_x_d = cur_x_q;
        cur_eps_d = cur_eps_q;
        iter_d = iter_q;
        count_d = count_q;
        req_ready = '0;
        eng_start = 1'b0;
        resp_valid = 1'b0;
`ifdef SAWTOOTH_SCHED_WATCHDOG_EN
        wd_d = wd_q;
        err_d = err_q;
`endif
        unique case (state_q)
            IDLE: if (gnt_found) begin
                req_ready = {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
                id_d = gnt_id;
                cur_x_d = req_x[gnt_id*PRECISION +: PRECISION];
                cur_eps_d = req_eps[gnt_id*PRECISION +: PRECISION];
                iter_d = (gnt_iter == 8'd0) ? 8'd1 : gnt_iter;
                count_d = '0;
`ifdef SAWTOOTH_SCHED_WATCHDOG_EN
                err_d = 1'b0;
`endif
                state_d = ISSUE;
            end
            ISSUE: begin
                eng_start = 1'b1;
`ifdef SAWTOOTH_SCHED_WATCHDOG_EN
                wd_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: if (eng_done) begin
                cur_x_d = eng_result;
                count_d = count_q + 8'd1;
                state_d = (count_q + 8'd1 == iter_q) ? RESP : ISSUE;
            end
`ifdef SAWTOOTH_SCHED_WATCHDOG_EN
            else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                err_d = 1'b1;
                state_d = RESP;
            end else begin
                wd_d = wd_q + 1'b1;
            end
`endif
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    last_d = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q <= 3'(NREQ - 1);
            id_q <= '0;
            cur_x_q <= '0;
            cur_eps_q <= '0;
            iter_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            id_q <= id_d;
            cur_x_q <= cur_x_d;
            cur_eps_q <= cur_eps_d;
            iter_q <= iter_d;
            count_q <= count_d;
        end
    end
`ifdef SAWTOOTH_SCHED_WATCHDOG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_q <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            err_q <= err_d;
        end
    end
    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif
    assign resp_id = id_q;
    assign resp_data = cur_x_q;
    assign eng_x = cur_x_q;
    assign eng_eps = cur_eps_q;
endmodule

// File: tb/tb_sawtooth_sched.sv
// tb_sawtooth_sched: scoreboard bench for sawtooth_sched with a 40-cycle engine model,
// directed scenarios and randomized requesters checked against a behavioural model.
`timescale 1ns/1ps
module tb_sawtooth_sched;
    localparam int NREQ = 4, P = 32, TO = 16, LE = 40;
    logic clk = 1'b0, reset = 1'b0;
    logic [NREQ-1:0] req_valid = '0;
    logic [NREQ*P-1:0] req_x = '0, req_eps = '0;
    logic [NREQ*8-1:0] req_iter = '0;
    logic [NREQ-1:0] req_ready;
    logic resp_valid, resp_err, eng_start;
    logic resp_ready = 1'b0, eng_done = 1'b0;
    logic [2:0] resp_id;
    logic [P-1:0] resp_data, eng_x, eng_eps;
    logic [P-1:0] eng_result = '0;

    typedef struct { logic [31:0] x; logic [31:0] eps; logic [7:0] iter; } req_t;
    typedef struct { logic [2:0] id; logic [31:0] data; logic err; int rise; } exp_t;
    typedef struct { logic [31:0] x; logic [31:0] eps; } op_t;

    req_t rq[NREQ][$];
    req_t held[NREQ];
    exp_t exp_q[$];
    op_t eng_q[$];
    int served[$];
    int tests = 0, fails = 0, cyc = 0;
    int idle_from = 0, last_m = NREQ - 1;
    int n_starts = 0, n_resps = 0;
    logic [31:0] last_data = '0;
    bit gap = 0, mute = 0, bp = 0, live = 0;

    sawtooth_sched #(.NREQ(NREQ), .PRECISION(P), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_x(req_x), .req_eps(req_eps),
        .req_iter(req_iter), .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .resp_ready(resp_ready), .eng_start(eng_start),
        .eng_x(eng_x), .eng_eps(eng_eps), .eng_done(eng_done), .eng_result(eng_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // eps = 1.0 is modelled exactly as x mod 1 for x in [0,2); other operands get an arbitrary deterministic map.
    function automatic logic [31:0] saw(input logic [31:0] x, input logic [31:0] e);
        logic [22:0] f;
        int p;
        if (e == 32'h3F800000 && x < 32'h3F800000) return x;
        if (e == 32'h3F800000 && x < 32'h40000000) begin
            f = x[22:0];
            if (f == 23'd0) return 32'h0;
            p = 22;
            while (!f[p]) p--;
            return {1'b0, 8'(127 + p - 23), 23'(f << (23 - p))};
        end
        return {x[15:0] ^ e[31:16], x[31:16] + e[15:0]};
    endfunction

    function automatic int rr(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.x = $urandom_range(0, 1) ? (32'h3F000000 | ($urandom & 32'h00FFFFFF)) : $urandom;
        r.eps = $urandom_range(0, 1) ? 32'h3F800000 : $urandom;
        r.iter = 8'($urandom_range(0, 4));
        return r;
    endfunction

    // Engine model: done pulse LE cycles after the start cycle; operands checked against the scoreboard.
    initial begin : engine
        int cnt;
        op_t cap, e;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            eng_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_done = 1'b1;
                    eng_result = saw(cap.x, cap.eps);
                end
            end
            @(negedge clk);
            if (eng_start && !reset) begin
                n_starts++;
                if (eng_q.size() == 0) check("eng_start_unexpected", 1, 0);
                else begin
                    e = eng_q.pop_front();
                    check("eng_x", eng_x, e.x);
                    check("eng_eps", eng_eps, e.eps);
                end
                cap = '{eng_x, eng_eps};
                live = 1;
                if (!mute) cnt = LE;
            end else if (cnt > 0 && live) begin
                check("eng_x_stable", eng_x, cap.x);
            end
        end
    end

    // Requester driver plus grant prediction; every accept pushes the expected response.
    initial begin : driver
        bit acc[NREQ];
        int w, n;
        logic [31:0] v;
        for (int i = 0; i < NREQ; i++) acc[i] = 0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (reset) begin
                    req_valid[i] = 1'b0;
                    acc[i] = 0;
                end else if (acc[i] || !req_valid[i]) begin
                    acc[i] = 0;
                    if (rq[i].size() > 0 && (!gap || $urandom_range(0, 2) != 0)) begin
                        held[i] = rq[i].pop_front();
                        req_x[i*P +: P] = held[i].x;
                        req_eps[i*P +: P] = held[i].eps;
                        req_iter[i*8 +: 8] = held[i].iter;
                        req_valid[i] = 1'b1;
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            if (!reset) begin
                if (cyc >= idle_from && req_valid != '0) begin
                    w = rr(last_m, req_valid);
                    check("req_ready_grant", req_ready, 64'(1) << w);
                    acc[w] = 1;
                    idle_from = 1 << 30;
                    n = (held[w].iter == 8'd0) ? 1 : int'(held[w].iter);
                    v = held[w].x;
                    if (mute) begin
                        eng_q.push_back('{v, held[w].eps});
`ifdef SAWTOOTH_SCHED_WATCHDOG_EN
                        exp_q.push_back('{3'(w), v, 1'b1, cyc + 2 + TO});
`endif
                    end else begin
                        for (int k = 0; k < n; k++) begin
                            eng_q.push_back('{v, held[w].eps});
                            v = saw(v, held[w].eps);
                        end
                        exp_q.push_back('{3'(w), v, 1'b0, cyc + 1 + n * (LE + 1)});
                    end
                end else begin
                    check("req_ready_idle", req_ready, 0);
                end
            end
        end
    end

    // Response monitor: pops the scoreboard on each new response and checks it every cycle it is held.
    initial begin : monitor
        bit seen;
        exp_t cur;
        seen = 0;
        forever begin
            @(posedge clk); #1;
            resp_ready = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (reset) begin
                seen = 0;
            end else if (resp_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", 1, 0);
                        cur = '{resp_id, resp_data, resp_err, cyc};
                    end else begin
                        cur = exp_q.pop_front();
                        check("resp_rise_cycle", cyc, cur.rise);
                    end
                    seen = 1;
                end
                check("resp_id", resp_id, cur.id);
                check("resp_data", resp_data, cur.data);
                check("resp_err", resp_err, cur.err);
                if (resp_ready) begin
                    seen = 0;
                    n_resps++;
                    last_data = resp_data;
                    served.push_back(int'(resp_id));
                    last_m = int'(cur.id);
                    idle_from = cyc + 1;
                end
            end else if (seen) begin
                check("resp_valid_held", 0, 1);
                seen = 0;
            end
        end
    end

    function automatic bit busy();
        if (exp_q.size() != 0 || req_valid != '0 || cyc < idle_from) return 1;
        for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) return 1;
        return 0;
    endfunction

    task automatic wait_idle(input int budget, input string name);
        int c;
        c = 0;
        while (busy() && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({name, "_done_in_budget"}, c < budget, 1);
    endtask

    task automatic wait_resp(input int budget);
        int c;
        c = 0;
        while (!resp_valid && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("resp_valid_seen", resp_valid, 1);
    endtask

    task automatic apply_reset();
        @(posedge clk); #2;
        reset = 1'b1;
        live = 0;
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        exp_q.delete();
        eng_q.delete();
        idle_from = 0;
        last_m = NREQ - 1;
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_eng_start", eng_start, 0);
        check("rst_eng_x", eng_x, 0);
        check("rst_eng_eps", eng_eps, 0);
        @(posedge clk); #2;
        reset = 1'b0;
    endtask

    initial begin : main
        int s, r0, n;
        int order[6];
        order = '{0, 1, 3, 0, 1, 3};
        apply_reset();
        // single iteration: 1.5 mod 1 -> 0.5, response at T+42
        s = n_starts;
        rq[0].push_back('{32'h3FC00000, 32'h3F800000, 8'd1});
        wait_idle(200, "single");
        check("single_data", last_data, 32'h3F000000);
        check("single_id", served[$], 0);
        check("single_starts", n_starts - s, 1);
        // feedback over three iterations, response at T+124
        s = n_starts;
        rq[0].push_back('{32'h3FC00000, 32'h3F800000, 8'd3});
        wait_idle(400, "feedback");
        check("feedback_data", last_data, 32'h3F000000);
        check("feedback_starts", n_starts - s, 3);
        // round robin from reset with continuous re-requests
        apply_reset();
        served.delete();
        for (int j = 0; j < 2; j++) begin
            rq[0].push_back('{32'h3FC00000, 32'h3F800000, 8'd1});
            rq[1].push_back('{32'h3F400000, 32'h3F800000, 8'd1});
            rq[3].push_back('{32'h3FE00000, 32'h3F800000, 8'd0});
        end
        wait_idle(1000, "round_robin");
        check("rr_count", served.size(), 6);
        for (int j = 0; j < 6 && j < served.size(); j++) check($sformatf("rr_order_%0d", j), served[j], order[j]);
        // response backpressure with another requester pending
        bp = 1;
        rq[2].push_back('{32'h3FA00000, 32'h3F800000, 8'd1});
        rq[1].push_back('{32'h12345678, 32'h9ABCDEF0, 8'd2});
        wait_resp(200);
        repeat (10) @(negedge clk);
        check("bp_resp_valid_held", resp_valid, 1);
        bp = 0;
        wait_idle(400, "backpressure");
        // reset in the middle of an engine wait; the late done must be ignored
        rq[0].push_back('{32'h3FC00000, 32'h3F800000, 8'd1});
        repeat (12) @(negedge clk);
        apply_reset();
        r0 = n_resps;
        s = n_starts;
        repeat (60) @(negedge clk);
        check("rst_no_resp", n_resps, r0);
        check("rst_no_restart", n_starts, s);
        check("rst_resp_valid_low", resp_valid, 0);
        // engine that never answers
        mute = 1;
        rq[1].push_back('{32'h3FC00000, 32'h3F800000, 8'd5});
`ifdef SAWTOOTH_SCHED_WATCHDOG_EN
        wait_idle(200, "watchdog");
        check("wd_data", last_data, 32'h3FC00000);
        check("wd_id", served[$], 1);
        mute = 0;
`else
        r0 = n_resps;
        repeat (100) @(negedge clk);
        check("nowd_no_resp", n_resps, r0);
        check("nowd_resp_valid_low", resp_valid, 0);
        mute = 0;
        apply_reset();
`endif
        // randomized bursts
        gap = 1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                n = $urandom_range(0, 3);
                for (int j = 0; j < n; j++) rq[i].push_back(rand_req());
            end
            wait_idle(4000, "random");
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : global_guard
        #1500000;
        $display("FAIL global_timeout: got no finish, expected finish before 1.5ms");
        $fatal(1);
    end
endmodule

// File: doc/sawtooth_sched.md
# sawtooth_sched

Round-robin scheduler that shares one sawtooth-map evaluation engine between `NREQ` requesters. It is the front end of the chaos key-stream path: each requester submits a seed `x`, a width `epsilon` and an iteration count. The scheduler grants one requester at a time and runs the map x ← saw(x, ε) the requested number of times by feeding the engine result back as the next `x`. It returns the final value with a valid/ready response.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `PRECISION`, 32: IEEE-754 word width.
- `TIMEOUT`, 255: engine watchdog limit in cycles. Used only with the macro.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  per-requester request.
- `req_x`  in  NREQ*PRECISION  seed, requester i in slice [i*32 +: 32].
- `req_eps`  in  NREQ*PRECISION  epsilon, same slicing.
- `req_iter`  in  NREQ*8  iteration count. 0 is treated as 1.
- `req_ready`  out  NREQ  one-hot acceptance pulse.
- `resp_valid`  out  1  result available.
- `resp_id`  out  3  index of the served requester.
- `resp_data`  out  PRECISION  final x.
- `resp_err`  out  1  watchdog abort flag. Tied 0 without the macro.
- `resp_ready`  in  1  consumer accepts the response.
- `eng_start`  out  1  one-cycle start pulse to the engine.
- `eng_x`, `eng_eps`  out  PRECISION  engine operands, stable from start until done.
- `eng_done`  in  1  one-cycle completion pulse from the engine.
- `eng_result`  in  PRECISION  engine output, valid with `eng_done`.

## Operation
- **States:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If any `req_valid` is high, grant the first set bit searching from `last+1` modulo NREQ.
  - Assert the matching `req_ready` bit for that cycle.
  - Latch x, eps and iter (0→1) into `cur_x`, `cur_eps`, `iter`, and set `count` = 0.
  - Next state ISSUE.
- **ISSUE:** `eng_start` = 1 and `eng_x` = `cur_x`. Next state WAIT.
- **WAIT:** on `eng_done`, `cur_x` ← `eng_result` and `count` increments. If `count`+1 == `iter`, go to RESP; otherwise go to ISSUE.
- **RESP:**
  - Hold `resp_valid` = 1 with `resp_id`, `resp_data` = `cur_x` and `resp_err` stable.
  - On `resp_ready`, set `last` ← granted id and return to IDLE.
- **Requester contract:** hold `req_valid` and its data stable until `req_ready`. Dropping `req_valid` before the grant withdraws the request.
- **Stray `eng_done`** outside WAIT is ignored.
- **Arithmetic:** the scheduler performs no FP arithmetic. Values pass through bit-exact.
- **Fairness:** a requester that re-asserts immediately after service is not granted again while any other request is pending.
- **Reset, at any time including mid-iteration:**
  - State goes to IDLE and `last` = NREQ-1, so requester 0 has first priority.
  - `count`, `cur_x` and `cur_eps` clear.
  - All outputs go to 0.
  - An in-flight engine result arriving after reset is ignored.

## Timing
- The accept cycle is T, when `req_valid` & `req_ready` are both high.
- `eng_start` is asserted at T+1.
- With engine latency Le (done Le cycles after start), each iteration costs Le+1 cycles.
- `resp_valid` first rises at T+1+n·(Le+1), for n = iterations.
- The earliest next grant is the cycle after the `resp_valid`&`resp_ready` handshake.
- `resp_ready` may be high before `resp_valid`. Completion then takes one RESP cycle.
- `req_ready` is never asserted outside IDLE. At most one bit is set.

## Configuration
- **Macro `SAWTOOTH_SCHED_WATCHDOG_EN`:**
  - A cycle counter clears on every `eng_start` and increments in WAIT.
  - If it reaches `TIMEOUT` before `eng_done`, the scheduler goes to RESP with `resp_err` = 1 and `resp_data` = the last good `cur_x`.
  - A late `eng_done` after the abort is ignored.
- **Without the macro:** no counter, `resp_err` = 0 constant, and WAIT waits indefinitely.

## Test plan
Behavioural engine model, Le = 40.
- **Reset values:** reset asserted mid-WAIT → next cycle all outputs 0 and state IDLE. A later `eng_done` produces no response.
- **Single iteration:** requester 0 with x = 0x3FC00000 (1.5), eps = 0x3F800000, iter = 1 → `eng_start` at T+1, `resp_valid` at T+42 with `resp_data` = 0x3F000000 (0.5) and `resp_id` = 0.
- **Feedback:** iter = 3, same operands → exactly 3 `eng_start` pulses. The second and third carry `eng_x` = 0x3F000000. Response is 0x3F000000 at T+124.
- **Round robin:** requesters 0, 1 and 3 valid together and continuously re-requesting → service order 0, 1, 3, 0, 1, 3.
- **Response backpressure:** `resp_ready` held low for 10 cycles → `resp_valid` and data held stable, no `req_ready` pulses. Release → IDLE on the next cycle.
- **Watchdog (macro on, TIMEOUT = 16):** engine never signals done → `resp_err` = 1 about 17 cycles after start, with `resp_data` = the seed. With the macro off, the block stays in WAIT.
